flopr_pipe: RTL and testbench

- Resettable D register for the RISC-V core datapath, e.g. PC register and pipeline holding registers.
- Captures `d` on every rising clock edge and presents it on `q`.
- An asynchronous active-low reset forces the contents to a constant.
- Optionally chains several identical stages to provide a fixed multi-cycle delay.

---
 rtl/flopr_pipe_pkg.sv | 18 +
 rtl/flop_stage.sv | 34 +++
 rtl/flopr_pipe.sv | 59 +++++
 tb/tb_flopr_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/flopr_pipe_pkg.sv
// -----------------------------------------------------------------------------
// flopr_pipe_pkg
//   Shared constants for the resettable register pipeline: the legal range of
//   the STAGES parameter and a helper that tests a stage count against it.
//   WIDTH and RESET_VALUE stay per-instance parameters and are not held here.
// -----------------------------------------------------------------------------
package flopr_pipe_pkg;

    // Smallest and largest supported number of chained register stages.
    localparam int MIN_STAGES = 1;
    localparam int MAX_STAGES = 16;

    // True when a requested stage count can be built.
    function automatic bit stages_legal(input int n);
        return (n >= MIN_STAGES) && (n <= MAX_STAGES);
    endfunction

endpackage : flopr_pipe_pkg

// File: rtl/flop_stage.sv
// -----------------------------------------------------------------------------
// flop_stage
//   One WIDTH-bit D register with asynchronous active-low reset. It captures
//   d on every rising clk edge. While reset is low the register holds
//   RESET_VALUE, and that load takes effect at once, without a clock edge.
//
// Ports
//   clk    in   1      clock, rising-edge active
//   reset  in   1      asynchronous reset, active low
//   d      in   WIDTH  data input
//   q      out  WIDTH  registered data
// -----------------------------------------------------------------------------
module flop_stage #(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: the reset term sits in the sensitivity list and is tested first, so
    // it wins over a coincident clock edge. Sequential state uses <= so that every
    // stage of a chain samples its neighbour's old value on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= d;
        end
    end

endmodule : flop_stage

// File: rtl/flopr_pipe.sv
// -----------------------------------------------------------------------------
// flopr_pipe
//   Resettable D register for the core datapath, used for the PC register and
//   for pipeline holding registers. STAGES identical flop_stage instances are
//   chained, so q reflects d exactly STAGES rising edges later. Asserting reset
//   flushes every stage to RESET_VALUE at once. After release the chain refills
//   from d, and q shows RESET_VALUE for the first STAGES-1 edges.
//   There is no enable and no synchronous clear: every edge captures.
//
// Parameters
//   WIDTH        data width of d and q
//   RESET_VALUE  value loaded into every stage while reset is low
//   STAGES       number of register stages, 1..16 (checked at elaboration)
//
// Ports
//   clk    in   1      clock, rising-edge active
//   reset  in   1      asynchronous reset, active low
//   d      in   WIDTH  data input
//   q      out  WIDTH  output of the last stage
// -----------------------------------------------------------------------------
module flopr_pipe
    import flopr_pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               STAGES      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Elaboration fails if the stage count is outside the supported range.
    if (!stages_legal(STAGES)) begin : g_bad_stages
        $error("flopr_pipe: STAGES=%0d is outside %0d..%0d",
               STAGES, MIN_STAGES, MAX_STAGES);
    end

    // chain[0] is the input. chain[i+1] is the output of stage i.
    logic [STAGES:0][WIDTH-1:0] chain;

    assign chain[0] = d;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        flop_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .d     (chain[i]),
            .q     (chain[i+1])
        );
    end

    assign q = chain[STAGES];

endmodule : flopr_pipe

// File: tb/tb_flopr_pipe.sv
// -----------------------------------------------------------------------------
// tb_flopr_pipe
//   Self-checking bench for flopr_pipe. Five instances are built:
//     a: 32 bits, 1 stage,   reset value 0
//     b: 32 bits, 3 stages,  reset value 0xA5
//     c: 1 bit,   1 stage,   reset value 1
//     d: 64 bits, 1 stage,   reset value 0xDEADBEEF0000FFFF
//     e: 8 bits,  16 stages, reset value 0x3C
//   The directed phases use fixed vector tables. The random phase checks every
//   instance against a history model: q equals the d value captured STAGES
//   edges ago, or RESET_VALUE when fewer edges than that have passed since reset.
// -----------------------------------------------------------------------------
module tb_flopr_pipe;

    localparam logic [31:0] RV_A = 32'h0;
    localparam logic [31:0] RV_B = 32'hA5;
    localparam logic [0:0]  RV_C = 1'b1;
    localparam logic [63:0] RV_D = 64'hDEAD_BEEF_0000_FFFF;
    localparam logic [7:0]  RV_E = 8'h3C;

    logic        clk = 1'b0;
    logic        ra, rb, rc, rd, re;
    logic [31:0] da, db;
    logic [0:0]  dc;
    logic [63:0] dd;
    logic [7:0]  de;
    logic [31:0] qa, qb;
    logic [0:0]  qc;
    logic [63:0] qd;
    logic [7:0]  qe;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    flopr_pipe #(.WIDTH(32), .RESET_VALUE(RV_A), .STAGES(1))  u_a (.clk(clk), .reset(ra), .d(da), .q(qa));
    flopr_pipe #(.WIDTH(32), .RESET_VALUE(RV_B), .STAGES(3))  u_b (.clk(clk), .reset(rb), .d(db), .q(qb));
    flopr_pipe #(.WIDTH(1),  .RESET_VALUE(RV_C), .STAGES(1))  u_c (.clk(clk), .reset(rc), .d(dc), .q(qc));
    flopr_pipe #(.WIDTH(64), .RESET_VALUE(RV_D), .STAGES(1))  u_d (.clk(clk), .reset(rd), .d(dd), .q(qd));
    flopr_pipe #(.WIDTH(8),  .RESET_VALUE(RV_E), .STAGES(16)) u_e (.clk(clk), .reset(re), .d(de), .q(qe));

    // ---------------------------------------------------------------- model
    // Each history list holds the d values captured since the last reset,
    // oldest first.
    logic [63:0] ha[$], hb[$], hc[$], hd[$], he[$];

    always @(posedge clk) if (ra === 1'b1) begin ha.push_back(64'(da)); if (ha.size() > 32) void'(ha.pop_front()); end
    always @(posedge clk) if (rb === 1'b1) begin hb.push_back(64'(db)); if (hb.size() > 32) void'(hb.pop_front()); end
    always @(posedge clk) if (rc === 1'b1) begin hc.push_back(64'(dc)); if (hc.size() > 32) void'(hc.pop_front()); end
    always @(posedge clk) if (rd === 1'b1) begin hd.push_back(dd);      if (hd.size() > 32) void'(hd.pop_front()); end
    always @(posedge clk) if (re === 1'b1) begin he.push_back(64'(de)); if (he.size() > 32) void'(he.pop_front()); end

    always @(negedge ra) ha.delete();
    always @(negedge rb) hb.delete();
    always @(negedge rc) hc.delete();
    always @(negedge rd) hd.delete();
    always @(negedge re) he.delete();

    function automatic logic [63:0] model_q(input logic [63:0] h[$], input int stages,
                                            input logic [63:0] rv);
        if (h.size() < stages) return rv;
        return h[h.size() - stages];
    endfunction

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        else             n_pass++;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_a"}, 64'(qa), model_q(ha, 1,  64'(RV_A)));
        check({tag, "_b"}, 64'(qb), model_q(hb, 3,  64'(RV_B)));
        check({tag, "_c"}, 64'(qc), model_q(hc, 1,  64'(RV_C)));
        check({tag, "_d"}, qd,      model_q(hd, 1,  RV_D));
        check({tag, "_e"}, 64'(qe), model_q(he, 16, 64'(RV_E)));
    endtask

    typedef struct {
        logic [63:0] d;
        logic [63:0] exp;
    } vec_t;

    vec_t load_vec[4];
    vec_t lat_vec[6];
    vec_t w1_vec[4];
    vec_t w64_vec[3];

    // Bound on total run time; a hang ends the run with a reported failure.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        load_vec = '{'{64'h21, 64'h21}, '{64'h2AA, 64'h2AA}, '{64'hF0, 64'hF0}, '{64'h318, 64'h318}};
        // Three-stage latency: d feeds 1,2,3,4 and then holds 4.
        lat_vec  = '{'{64'h1, 64'hA5}, '{64'h2, 64'hA5}, '{64'h3, 64'h1},
                     '{64'h4, 64'h2}, '{64'h4, 64'h3}, '{64'h4, 64'h4}};
        w1_vec   = '{'{64'h0, 64'h0}, '{64'h1, 64'h1}, '{64'h0, 64'h0}, '{64'h1, 64'h1}};
        w64_vec  = '{'{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF},
                     '{64'h0, 64'h0},
                     '{64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF}};

        // ------------------------------------------- async reset, no clock edge
        ra = 1'b1; rb = 1'b1; rc = 1'b1; rd = 1'b1; re = 1'b1;
        da = 32'h3F; db = '0; dc = '0; dd = '0; de = '0;
        #2;
        ra = 1'b0; rb = 1'b0; rc = 1'b0; rd = 1'b0; re = 1'b0;
        #1;
        check("rst_a", 64'(qa), 64'(RV_A));
        check("rst_b", 64'(qb), 64'(RV_B));
        check("rst_c", 64'(qc), 64'(RV_C));
        check("rst_d", qd,      RV_D);
        check("rst_e", 64'(qe), 64'(RV_E));

        // Reset held across a rising edge with d = 0x3F: q stays at reset value.
        @(negedge clk);
        check("rst_hold_a", 64'(qa), 64'h0);
        ra = 1'b1;
        @(negedge clk);
        check("release_a", 64'(qa), 64'h3F);

        // ------------------------------------------- sequential loads, 1 stage
        foreach (load_vec[i]) begin
            da = load_vec[i].d[31:0];
            @(posedge clk);
            #1 check("load_a", 64'(qa), load_vec[i].exp);
            da = ~load_vec[i].d[31:0];
            #2 check("hold_a", 64'(qa), load_vec[i].exp);
        end

        // Reset in the middle of operation, away from any edge.
        #2 ra = 1'b0;
        #1 check("midrst_a", 64'(qa), 64'h0);
        @(negedge clk);
        ra = 1'b1;
        da = 32'h55;
        @(posedge clk);
        #1 check("refill_a", 64'(qa), 64'h55);

        // Reset asserted in the same timestep as a rising edge.
        da = 32'hFFFF;
        @(posedge clk);
        ra = 1'b0;
        #1 check("prio_a", 64'(qa), 64'h0);
        @(negedge clk);
        ra = 1'b1;

        // ------------------------------------------- three-stage latency
        check("rst_b2", 64'(qb), 64'hA5);
        rb = 1'b1;
        foreach (lat_vec[i]) begin
            db = lat_vec[i].d[31:0];
            @(posedge clk);
            #1 check("lat_b", 64'(qb), lat_vec[i].exp);
        end
        // Fill the chain with 7, 8 behind the 4, then flush it mid-stream.
        db = 32'h7;
        @(posedge clk);
        db = 32'h8;
        @(posedge clk);
        #2 rb = 1'b0;
        #1 check("flush_b", 64'(qb), 64'hA5);
        @(negedge clk);
        rb = 1'b1;
        db = 32'h9;
        @(posedge clk);
        #1 check("flush_b_s2", 64'(qb), 64'hA5);
        db = 32'hA;
        @(posedge clk);
        #1 check("flush_b_s1", 64'(qb), 64'hA5);
        @(posedge clk);
        #1 check("refill_b", 64'(qb), 64'h9);

        // ------------------------------------------- width 1
        @(negedge clk);
        check("rst_c2", 64'(qc), 64'(RV_C));
        rc = 1'b1;
        foreach (w1_vec[i]) begin
            dc = w1_vec[i].d[0:0];
            @(posedge clk);
            #1 check("w1_c", 64'(qc), w1_vec[i].exp);
        end
        dc = 1'b0;
        #2 rc = 1'b0;
        #1 check("w1_rst_c", 64'(qc), 64'(RV_C));
        @(negedge clk);
        rc = 1'b1;

        // ------------------------------------------- width 64
        check("rst_d2", qd, RV_D);
        rd = 1'b1;
        foreach (w64_vec[i]) begin
            dd = w64_vec[i].d;
            @(posedge clk);
            #1 check("w64_d", qd, w64_vec[i].exp);
        end
        #2 rd = 1'b0;
        #1 check("w64_rst_d", qd, RV_D);
        @(negedge clk);
        rd = 1'b1;
        re = 1'b1;

        // ------------------------------------------- random against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            check_model("rand");
            da = $urandom;
            db = $urandom;
            dc = 1'($urandom);
            dd = {$urandom, $urandom};
            de = 8'($urandom);
            if (ra == 1'b0) begin
                if ($urandom_range(1, 0) == 1) begin
                    ra = 1'b1; rb = 1'b1; rc = 1'b1; rd = 1'b1; re = 1'b1;
                end
            end else if ($urandom_range(24, 0) == 0) begin
                ra = 1'b0; rb = 1'b0; rc = 1'b0; rd = 1'b0; re = 1'b0;
                #1 check_model("rand_rst");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_flopr_pipe
